laser_host: RTL and testbench

- Synthesizable host for the LASER block; the initiator side of the LASER point/DONE protocol.
- Buffers NPTS 4-bit (x,y) points loaded by a controller.
- On start: pulses LASER reset, streams one point per cycle, waits for DONE (with timeout), captures the two circle centres, then serially scores coverage against the buffered points.
- Used for on-chip self-test and as the reusable driver around LASER.

---
 rtl/laser_host.sv | 199 +++++++++++++++++++
 tb/tb_laser_host.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/laser_host.sv
// laser_host: initiator side of the LASER point/DONE protocol.
//
// Buffers NPTS 4-bit (x,y) points from a controller. On an accepted start it
// holds the LASER in reset for RST_CYCLES, streams one buffered point per
// cycle, waits (bounded by MAX_WAIT) for DONE, captures both circle centres
// and then scores, one point per cycle, how many buffered points fall inside
// either circle (squared distance <= RSQ).
//
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   ld_en, ld_x, ld_y     point load into the buffer (IDLE only)
//   start                 begin a run (IDLE with a full buffer only)
//   busy                  high in every state except IDLE
//   L_RST, X, Y           reset and point stream to LASER
//   DONE, C1X..C2Y        LASER result-ready and circle centres
//   res_valid             one-cycle pulse, results valid
//   cover_cnt             number of covered points
//   timeout, proto_err    run-end flags, held until the next accepted start
module laser_host #(
   parameter int NPTS       = 40,
   parameter int RST_CYCLES = 2,
   parameter int MAX_WAIT   = 50000,
   parameter int RSQ        = 16
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       ld_en,
   input  logic [3:0] ld_x,
   input  logic [3:0] ld_y,
   input  logic       start,
   output logic       busy,
   output logic       L_RST,
   output logic [3:0] X,
   output logic [3:0] Y,
   input  logic       DONE,
   input  logic [3:0] C1X,
   input  logic [3:0] C1Y,
   input  logic [3:0] C2X,
   input  logic [3:0] C2Y,
   output logic       res_valid,
   output logic [5:0] cover_cnt,
   output logic       timeout,
   output logic       proto_err
);

   localparam int PW   = $clog2(NPTS + 1);
   localparam int CMAX = (MAX_WAIT > RST_CYCLES) ? MAX_WAIT : RST_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [PW-1:0] PTS_FULL  = PW'(NPTS);
   localparam logic [PW-1:0] PTS_LAST  = PW'(NPTS - 1);
   localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);
   localparam logic [8:0]    RSQ_D     = 9'(RSQ);

   typedef enum logic [2:0] {
      S_IDLE, S_DRST, S_STREAM, S_WAIT, S_SCORE, S_REPORT
   } state_t;

   state_t state, state_nxt;

   logic [3:0]    pbuf_x [NPTS];
   logic [3:0]    pbuf_y [NPTS];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] idx;
   logic [PW-1:0] sidx;
   logic [CW-1:0] wait_cnt;
   logic [3:0]    c1x_q, c1y_q, c2x_q, c2y_q;

   logic load_ok, start_ok, wait_lim, cap_now, covered;
   logic [8:0] d1, d2;

   // |a-b|^2 with the difference taken as signed 5-bit; result is 0..225.
   function automatic logic [7:0] sq_diff(input logic [3:0] a, input logic [3:0] b);
      logic [4:0] d;
      logic [4:0] m;
      d = {1'b0, a} - {1'b0, b};
      m = d[4] ? (~d + 5'd1) : d;
      return {4'b0, m[3:0]} * {4'b0, m[3:0]};
   endfunction

   // A load never wraps: once full, further loads are dropped. Since a start
   // needs a full buffer, ld_en naturally wins over start while not full.
   assign load_ok  = (state == S_IDLE) && ld_en && (wr_ptr != PTS_FULL);
   assign start_ok = (state == S_IDLE) && start && (wr_ptr == PTS_FULL);
   // DONE on the limit cycle takes priority over the timeout.
   assign wait_lim = (wait_cnt == WAIT_LAST);
   assign cap_now  = (state == S_WAIT) && (DONE || wait_lim);

   // Index of the point to present next cycle while streaming.
   assign sidx = (state == S_STREAM) ? idx + 1'b1 : '0;

   // Coverage of the point being scored; sums kept at 9 bits (max 450).
   always_comb begin
      d1 = {1'b0, sq_diff(c1x_q, pbuf_x[idx])} + {1'b0, sq_diff(c1y_q, pbuf_y[idx])};
      d2 = {1'b0, sq_diff(c2x_q, pbuf_x[idx])} + {1'b0, sq_diff(c2y_q, pbuf_y[idx])};
      covered = (d1 <= RSQ_D) || (d2 <= RSQ_D);
   end

   // State register
   always_ff @(posedge CLK) begin
      if (RST) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start_ok) state_nxt = S_DRST;
         S_DRST:   if (wait_cnt == RST_LAST) state_nxt = S_STREAM;
         S_STREAM: begin
            if (DONE)                 state_nxt = S_REPORT;
            else if (idx == PTS_LAST) state_nxt = S_WAIT;
         end
         S_WAIT:   if (cap_now) state_nxt = S_SCORE;
         S_SCORE:  if (idx == PTS_LAST) state_nxt = S_REPORT;
         S_REPORT: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Moore outputs
   always_comb begin
      busy      = (state != S_IDLE);
      L_RST     = (state == S_DRST);
      res_valid = (state == S_REPORT);
   end

   // Point buffer; contents survive reset, only wr_ptr is cleared.
   always_ff @(posedge CLK) begin
      if (load_ok) begin
         pbuf_x[wr_ptr] <= ld_x;
         pbuf_y[wr_ptr] <= ld_y;
      end
   end

   // Datapath
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr    <= '0;
         idx       <= '0;
         wait_cnt  <= '0;
         X         <= '0;
         Y         <= '0;
         c1x_q     <= '0;
         c1y_q     <= '0;
         c2x_q     <= '0;
         c2y_q     <= '0;
         cover_cnt <= '0;
         timeout   <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         if (load_ok)                wr_ptr <= wr_ptr + 1'b1;
         else if (state == S_REPORT) wr_ptr <= '0;

         // wait_cnt doubles as the LASER reset-length counter.
         case (state)
            S_DRST:  wait_cnt <= (wait_cnt == RST_LAST) ? '0 : wait_cnt + 1'b1;
            S_WAIT:  wait_cnt <= cap_now ? '0 : wait_cnt + 1'b1;
            default: wait_cnt <= '0;
         endcase

         case (state)
            S_STREAM: idx <= (DONE || idx == PTS_LAST) ? '0 : idx + 1'b1;
            S_SCORE:  idx <= (idx == PTS_LAST) ? '0 : idx + 1'b1;
            default:  idx <= '0;
         endcase

         // X/Y load on the edge entering each STREAM cycle, so point 0 is
         // already on the bus in the first STREAM cycle.
         if (state_nxt == S_STREAM) begin
            X <= pbuf_x[sidx];
            Y <= pbuf_y[sidx];
         end else begin
            X <= '0;
            Y <= '0;
         end

         if (cap_now) begin
            c1x_q <= C1X;
            c1y_q <= C1Y;
            c2x_q <= C2X;
            c2y_q <= C2Y;
         end

         if (start_ok) begin
            cover_cnt <= '0;
            timeout   <= 1'b0;
            proto_err <= 1'b0;
         end else begin
            if (state == S_SCORE && covered)          cover_cnt <= cover_cnt + 1'b1;
            if (state == S_WAIT && !DONE && wait_lim) timeout   <= 1'b1;
            if (state == S_STREAM && DONE)            proto_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_laser_host.sv
// Testbench for laser_host: table of whole-run vectors plus hand-written
// sequences for load limits, start gating and reset in the middle of scoring.
module tb_laser_host;

   localparam int NPTS_T = 40;
   localparam int RSTC   = 2;
   localparam int MAXW   = 100;

   logic       CLK, RST, ld_en, start, DONE;
   logic [3:0] ld_x, ld_y, C1X, C1Y, C2X, C2Y;
   logic       busy, L_RST, res_valid, timeout, proto_err;
   logic [3:0] X, Y;
   logic [5:0] cover_cnt;

   laser_host #(.NPTS(NPTS_T), .RST_CYCLES(RSTC), .MAX_WAIT(MAXW), .RSQ(16)) dut (
      .CLK(CLK), .RST(RST), .ld_en(ld_en), .ld_x(ld_x), .ld_y(ld_y),
      .start(start), .busy(busy), .L_RST(L_RST), .X(X), .Y(Y),
      .DONE(DONE), .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
      .res_valid(res_valid), .cover_cnt(cover_cnt),
      .timeout(timeout), .proto_err(proto_err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0] fx, fy, rx, ry;      // first point, the other 39 points
      logic [3:0] c1x, c1y, c2x, c2y;  // centres presented on the capture cycle
      int k;                           // DONE k cycles into WAIT, -1 = never
      int ps;                          // DONE in this STREAM cycle (1-based), 0 = none
      int cov, to, pe, lat;            // expected results and start->res_valid latency
   } vec_t;

   vec_t tv[8];
   int   checks = 0;
   int   errors = 0;
   logic [3:0] mx[NPTS_T];
   logic [3:0] my[NPTS_T];
   int   mcnt = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   // Junk centres cover none of the test points; real centres appear only on
   // the cycle the host is supposed to capture them.
   task automatic set_centres(input logic real_c, input vec_t v);
      if (real_c) begin
         C1X = v.c1x; C1Y = v.c1y; C2X = v.c2x; C2Y = v.c2y;
      end else begin
         C1X = 4'd15; C1Y = 4'd0; C2X = 4'd15; C2Y = 4'd0;
      end
   endtask

   task automatic load_pt(input logic [3:0] x, input logic [3:0] y);
      ld_en = 1'b1; ld_x = x; ld_y = y;
      @(negedge CLK);
      ld_en = 1'b0;
      if (mcnt < NPTS_T) begin
         mx[mcnt] = x; my[mcnt] = y; mcnt++;
      end
   endtask

   // Cycle c is the clock period after the c-th edge counted from the edge
   // that accepts start; outputs are sampled and inputs driven at its negedge.
   task automatic run_vec(input vec_t v, input string nm);
      int cap, ctl_bad, x_bad, bad_c, lat;
      logic [3:0] ex, ey;
      cap = (v.k >= 0) ? RSTC + NPTS_T + 1 + v.k
                       : ((v.ps == 0) ? RSTC + NPTS_T + MAXW : -1);
      ctl_bad = 0; x_bad = 0; bad_c = -1; lat = -1;
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      for (int c = 1; c <= 400 && lat < 0; c++) begin
         if (c > RSTC && c <= RSTC + NPTS_T && (v.ps == 0 || c <= RSTC + v.ps)) begin
            ex = mx[c-RSTC-1]; ey = my[c-RSTC-1];
         end else begin
            ex = 4'd0; ey = 4'd0;
         end
         if (L_RST !== (c <= RSTC) || busy !== 1'b1) ctl_bad++;
         if (X !== ex || Y !== ey) begin
            x_bad++;
            if (bad_c < 0) bad_c = c;
         end
         if (res_valid === 1'b1) lat = c;
         else begin
            DONE = (v.k >= 0 && c == cap) || (v.ps > 0 && c == RSTC + v.ps);
            set_centres(c == cap, v);
            @(negedge CLK);
         end
      end
      DONE = 1'b0;
      set_centres(1'b0, v);
      chk({nm, " ctl"}, ctl_bad, 0);
      if (x_bad != 0) $display("  first stream deviation in cycle %0d", bad_c);
      chk({nm, " stream"}, x_bad, 0);
      chk({nm, " latency"}, lat, v.lat);
      chk({nm, " cover"}, int'(cover_cnt), v.cov);
      chk({nm, " timeout"}, int'(timeout), v.to);
      chk({nm, " proto_err"}, int'(proto_err), v.pe);
      @(negedge CLK);
      chk({nm, " rv_pulse"}, int'(res_valid), 0);
      chk({nm, " busy_end"}, int'(busy), 0);
      chk({nm, " cover_hold"}, int'(cover_cnt), v.cov);
      mcnt = 0;
   endtask

   function automatic vec_t mk(input int fx, fy, rx, ry, c1x, c1y, c2x, c2y,
                               input int k, ps, cov, to, pe, lat);
      vec_t v;
      v.fx = 4'(fx); v.fy = 4'(fy); v.rx = 4'(rx); v.ry = 4'(ry);
      v.c1x = 4'(c1x); v.c1y = 4'(c1y); v.c2x = 4'(c2x); v.c2y = 4'(c2y);
      v.k = k; v.ps = ps; v.cov = cov; v.to = to; v.pe = pe; v.lat = lat;
      return v;
   endfunction

   initial begin
      vec_t va;
      int bad, cnt;
      RST = 1'b1; ld_en = 1'b0; start = 1'b0; DONE = 1'b0;
      ld_x = '0; ld_y = '0;
      C1X = '0; C1Y = '0; C2X = '0; C2Y = '0;

      //          first  rest   C1      C2     k  ps cov to pe lat
      tv[0] = mk(5, 5, 5, 5,   5, 5,   0, 0,   10, 0, 40, 0, 0, 94);  // basic
      tv[1] = mk(0, 0, 15, 15, 4, 0,   15, 15, 0, 0,  40, 0, 0, 84);  // d=16 in
      tv[2] = mk(0, 0, 15, 15, 4, 1,   15, 15, 0, 0,  39, 0, 0, 84);  // d=17 out
      tv[3] = mk(5, 5, 5, 5,   5, 5,   6, 6,   3, 0,  40, 0, 0, 87);  // both circles
      tv[4] = mk(15, 6, 0, 0,  15, 6,  6, 15,  5, 0,  1, 0, 0, 89);   // d=261, 9-bit sum
      tv[5] = mk(2, 2, 9, 9,   2, 2,   0, 0,   -1, 0, 1, 1, 0, 183);  // timeout
      tv[6] = mk(5, 5, 5, 5,   5, 5,   5, 5,   -1, 7, 0, 0, 1, 10);   // DONE in STREAM
      tv[7] = mk(7, 8, 1, 14,  7, 12,  4, 14,  2, 0,  40, 0, 0, 86);  // flags clear

      repeat (2) @(negedge CLK);
      RST = 1'b0;
      chk("rst busy", int'(busy), 0);
      chk("rst lrst", int'(L_RST), 0);
      chk("rst res_valid", int'(res_valid), 0);
      chk("rst xy", int'({X, Y}), 0);
      chk("rst cover", int'(cover_cnt), 0);
      chk("rst flags", int'({timeout, proto_err}), 0);

      for (int i = 0; i < 8; i++) begin
         load_pt(tv[i].fx, tv[i].fy);
         for (int j = 1; j < NPTS_T; j++) load_pt(tv[i].rx, tv[i].ry);
         run_vec(tv[i], $sformatf("vec%0d", i));
      end

      // Start with 39 points is ignored; ld_en beats start on the 40th;
      // the 41st load is dropped.
      for (int j = 0; j < NPTS_T - 1; j++) load_pt(4'd3, 4'd3);
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      bad = 0;
      for (int j = 0; j < 5; j++) begin
         if (busy !== 1'b0) bad++;
         @(negedge CLK);
      end
      chk("start39 busy", bad, 0);
      start = 1'b1;
      load_pt(4'd3, 4'd3);
      start = 1'b0;
      chk("ld_start busy", int'(busy), 0);
      load_pt(4'd15, 4'd15);
      va = mk(3, 3, 3, 3, 3, 3, 3, 3, 1, 0, 40, 0, 0, 85);
      run_vec(va, "load41");

      // Reset in the middle of scoring after a timeout.
      for (int j = 0; j < NPTS_T; j++) load_pt(4'd5, 4'd5);
      va = mk(5, 5, 5, 5, 5, 5, 5, 5, -1, 0, 0, 0, 0, 0);
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      for (int c = 1; c < 150; c++) begin
         set_centres(c == RSTC + NPTS_T + MAXW, va);
         @(negedge CLK);
      end
      set_centres(1'b0, va);
      chk("score busy", int'(busy), 1);
      chk("score timeout", int'(timeout), 1);
      chk("score cover", int'(cover_cnt), 7);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      mcnt = 0;
      chk("midrst busy", int'(busy), 0);
      chk("midrst lrst_rv", int'({L_RST, res_valid}), 0);
      chk("midrst xy", int'({X, Y}), 0);
      chk("midrst cover", int'(cover_cnt), 0);
      chk("midrst flags", int'({timeout, proto_err}), 0);
      cnt = 0;
      for (int j = 0; j < 120; j++) begin
         if (res_valid !== 1'b0 || busy !== 1'b0) cnt++;
         @(negedge CLK);
      end
      chk("midrst quiet", cnt, 0);
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      chk("midrst wr_ptr", int'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
